// File: rtl/vga_pkg.sv
// Shared timing defaults, colour constants and FSM encoding for the VGA canvas front-end.
package vga_pkg;

    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BP      = 88;
    localparam int DEF_H_ACT     = 800;
    localparam int DEF_H_FP      = 40;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BP      = 23;
    localparam int DEF_V_ACT     = 600;
    localparam int DEF_V_FP      = 1;
    localparam int DEF_GRID_LOG2 = 5;
    localparam int DEF_CELL_LOG2 = 4;
    localparam int DEF_CUR_SIZE  = 8;
    localparam int DEF_CW        = 11;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t C_BLANK     = 12'h222;
    localparam rgb_t C_WHITE     = 12'hFFF;
    localparam rgb_t C_INK       = 12'hF0F;
    localparam rgb_t C_CUR_IDLE  = 12'hF00;
    localparam rgb_t C_CUR_DRAW  = 12'h00F;
    localparam rgb_t C_CUR_ERASE = 12'h0F0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // True when pos lies in [org, org+len); unsigned, so pos < org is simply a miss.
    function automatic logic in_span(input logic [15:0] pos, input logic [15:0] org,
                                     input logic [15:0] len);
        return (pos >= org) && ((pos - org) < len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters: positions relative to the active area, active flag,
// raw (unregistered) active-low syncs and the frame-start marker.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_ACT  = DEF_H_ACT,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_ACT  = DEF_V_ACT,
    parameter int V_FP   = DEF_V_FP,
    parameter int CW     = DEF_CW
) (
    input  logic          clkVga,
    input  logic          iRstN,
    output logic [CW-1:0] oHPos,
    output logic [CW-1:0] oVPos,
    output logic          oActive,
    output logic          oHsRaw,
    output logic          oVsRaw,
    output logic          oFrameStartRaw
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [CW-1:0] L_H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] L_H_SYNC = CW'(H_SYNC);
    localparam logic [CW-1:0] L_H_ACT0 = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] L_H_ACT1 = CW'(H_SYNC + H_BP + H_ACT);
    localparam logic [CW-1:0] L_V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] L_V_SYNC = CW'(V_SYNC);
    localparam logic [CW-1:0] L_V_ACT0 = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] L_V_ACT1 = CW'(V_SYNC + V_BP + V_ACT);

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    // The line counter steps on the pixel clock when the pixel counter wraps.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == L_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + CW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CW'(1);
        end
    end

    assign oHPos          = r_h_cnt - L_H_ACT0;
    assign oVPos          = r_v_cnt - L_V_ACT0;
    assign oActive        = (r_h_cnt >= L_H_ACT0) && (r_h_cnt < L_H_ACT1)
                         && (r_v_cnt >= L_V_ACT0) && (r_v_cnt < L_V_ACT1);
    assign oHsRaw         = (r_h_cnt >= L_H_SYNC);
    assign oVsRaw         = (r_v_cnt >= L_V_SYNC);
    assign oFrameStartRaw = (r_h_cnt == '0) && (r_v_cnt == '0);

endmodule

// File: rtl/vga_canvas_renderer.sv
// VGA front-end for digit capture: 1-bit drawing canvas with pen draw/erase, cursor overlay,
// sequential full-canvas clear and a single-cell readout port for the classifier loader.
module vga_canvas_renderer
    import vga_pkg::*;
#(
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int H_ACT     = DEF_H_ACT,
    parameter int H_FP      = DEF_H_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int V_ACT     = DEF_V_ACT,
    parameter int V_FP      = DEF_V_FP,
    parameter int GRID_LOG2 = DEF_GRID_LOG2,
    parameter int CELL_LOG2 = DEF_CELL_LOG2,
    parameter int CUR_SIZE  = DEF_CUR_SIZE,
    parameter int CW        = DEF_CW
) (
    input  logic                   clkVga,
    input  logic                   iRstN,
    input  logic [CW-1:0]          iCurX,
    input  logic [CW-1:0]          iCurY,
    input  logic                   iPenDraw,
    input  logic                   iPenErase,
    input  logic                   iClear,
    input  logic                   iRdReq,
    input  logic [2*GRID_LOG2-1:0] iRdAddr,
    output logic                   oRdData,
    output logic                   oRdValid,
    output logic                   oBusy,
    output logic                   oHs,
    output logic                   oVs,
    output logic [3:0]             oRed,
    output logic [3:0]             oGreen,
    output logic [3:0]             oBlue,
    output logic                   oFrameStart
);

    localparam int AW      = 2 * GRID_LOG2;
    localparam int N_CELLS = 1 << AW;

    localparam logic [CW-1:0] L_GRID   = CW'(1 << GRID_LOG2);
    localparam logic [CW-1:0] L_CANVAS = CW'(1 << (GRID_LOG2 + CELL_LOG2));

    logic [CW-1:0] w_hpos;
    logic [CW-1:0] w_vpos;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_frame_start_raw;

    vga_timing_gen #(
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .CW     (CW)
    ) u_timing (
        .clkVga         (clkVga),
        .iRstN          (iRstN),
        .oHPos          (w_hpos),
        .oVPos          (w_vpos),
        .oActive        (w_active),
        .oHsRaw         (w_hs_raw),
        .oVsRaw         (w_vs_raw),
        .oFrameStartRaw (w_frame_start_raw)
    );

    state_e        r_state;
    logic [AW-1:0] r_clr_addr;
    logic          w_busy;

    assign w_busy = (r_state == S_CLEAR);

    // A clear walks every cell once; further iClear pulses are ignored until it finishes.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            r_state    <= S_IDLE;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iClear) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_clr_addr <= r_clr_addr + AW'(1);
                    if (&r_clr_addr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [CW-1:0] w_pen_col;
    logic [CW-1:0] w_pen_row;
    logic          w_pen_in_grid;
    logic [AW-1:0] w_pen_addr;

    assign w_pen_col     = iCurX >> CELL_LOG2;
    assign w_pen_row     = iCurY >> CELL_LOG2;
    assign w_pen_in_grid = (w_pen_col < L_GRID) && (w_pen_row < L_GRID);
    assign w_pen_addr    = {w_pen_row[GRID_LOG2-1:0], w_pen_col[GRID_LOG2-1:0]};

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic          w_wdata;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_pen_addr;
        w_wdata = 1'b0;
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
        end else if (w_pen_in_grid && iPenErase) begin
            w_we    = 1'b1;
        end else if (w_pen_in_grid && iPenDraw) begin
            w_we    = 1'b1;
            w_wdata = 1'b1;
        end
    end

    // Canvas has no reset; it is only meaningful after the first clear.
    logic r_canvas [N_CELLS];

    always_ff @(posedge clkVga) begin
        if (w_we) begin
            r_canvas[w_waddr] <= w_wdata;
        end
    end

    logic w_rd_accept;
    logic r_rd_valid;
    logic r_rd_data;

    assign w_rd_accept = iRdReq && !w_busy;

    // Sampled on the same edge as any pen write, so a colliding read sees the old bit.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= r_canvas[iRdAddr];
            end
        end
    end

    logic [AW-1:0] w_disp_addr;
    logic          w_in_canvas;
    logic          w_ink;
    logic          w_cursor_hit;
    rgb_t          w_rgb_next;

    assign w_disp_addr  = {w_vpos[CELL_LOG2 +: GRID_LOG2], w_hpos[CELL_LOG2 +: GRID_LOG2]};
    assign w_in_canvas  = (w_hpos < L_CANVAS) && (w_vpos < L_CANVAS);
    assign w_ink        = r_canvas[w_disp_addr];
    assign w_cursor_hit = in_span(16'(w_hpos), 16'(iCurX), 16'(CUR_SIZE))
                       && in_span(16'(w_vpos), 16'(iCurY), 16'(CUR_SIZE));

    always_comb begin
        w_rgb_next = C_BLANK;
        if (w_active) begin
            if (w_cursor_hit) begin
                if (w_busy) begin
                    w_rgb_next = C_CUR_IDLE;
                end else if (iPenErase) begin
                    w_rgb_next = C_CUR_ERASE;
                end else if (iPenDraw) begin
                    w_rgb_next = C_CUR_DRAW;
                end else begin
                    w_rgb_next = C_CUR_IDLE;
                end
            end else if (w_in_canvas && w_ink) begin
                w_rgb_next = C_INK;
            end else begin
                w_rgb_next = C_WHITE;
            end
        end
    end

    rgb_t r_rgb;
    logic r_hs;
    logic r_vs;
    logic r_frame_start;

    // Colour, syncs and frame marker share one register stage so they stay aligned.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            r_rgb         <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb_next;
            r_hs          <= w_hs_raw;
            r_vs          <= w_vs_raw;
            r_frame_start <= w_frame_start_raw;
        end
    end

    assign oRed        = r_rgb.r;
    assign oGreen      = r_rgb.g;
    assign oBlue       = r_rgb.b;
    assign oHs         = r_hs;
    assign oVs         = r_vs;
    assign oFrameStart = r_frame_start;
    assign oBusy       = w_busy;
    assign oRdValid    = r_rd_valid;
    assign oRdData     = r_rd_data;

endmodule

// File: tb/tb_vga_canvas_renderer.sv
// Directed bench for vga_canvas_renderer: sync timing, clear, pen draw/erase, overlay colours,
// readout rules and asynchronous reset during a clear. Vertical blanking is shortened to fit.
module tb_vga_canvas_renderer;

    localparam int H_TOT = 1056;
    localparam int H_OFF = 216;
    localparam int V_OFF = 6;

    logic        clkVga = 1'b0;
    logic        iRstN;
    logic [10:0] iCurX;
    logic [10:0] iCurY;
    logic        iPenDraw;
    logic        iPenErase;
    logic        iClear;
    logic        iRdReq;
    logic [9:0]  iRdAddr;
    logic        oRdData;
    logic        oRdValid;
    logic        oBusy;
    logic        oHs;
    logic        oVs;
    logic [3:0]  oRed;
    logic [3:0]  oGreen;
    logic [3:0]  oBlue;
    logic        oFrameStart;

    int checks   = 0;
    int errors   = 0;
    int n        = 0;
    int fs_count = 0;

    vga_canvas_renderer #(
        .V_SYNC (4),
        .V_BP   (2),
        .V_ACT  (48),
        .V_FP   (1)
    ) dut (
        .clkVga      (clkVga),
        .iRstN       (iRstN),
        .iCurX       (iCurX),
        .iCurY       (iCurY),
        .iPenDraw    (iPenDraw),
        .iPenErase   (iPenErase),
        .iClear      (iClear),
        .iRdReq      (iRdReq),
        .iRdAddr     (iRdAddr),
        .oRdData     (oRdData),
        .oRdValid    (oRdValid),
        .oBusy       (oBusy),
        .oHs         (oHs),
        .oVs         (oVs),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oFrameStart (oFrameStart)
    );

    always #5 clkVga = ~clkVga;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkVga);
        n++;
        #1;
        if (oFrameStart === 1'b1) fs_count++;
    endtask

    task automatic wait_to(input string tag, input int target);
        chk({tag, "_reach"}, 32'(n <= target), 32'd1);
        while (n < target) tick();
    endtask

    task automatic check_px(input string tag, input int h, input int v, input logic [11:0] exp);
        wait_to(tag, (v + V_OFF) * H_TOT + H_OFF + h + 1);
        chk(tag, {20'd0, oRed, oGreen, oBlue}, {20'd0, exp});
    endtask

    task automatic rd(input string tag, input int addr, input logic exp);
        iRdReq  = 1'b1;
        iRdAddr = 10'(addr);
        tick();
        iRdReq  = 1'b0;
        chk({tag, "_valid"}, 32'(oRdValid), 32'd1);
        chk(tag, 32'(oRdData), 32'(exp));
    endtask

    task automatic run_clear(input string tag, input bit poke);
        int cnt;
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        cnt = 0;
        while (oBusy === 1'b1 && cnt < 2000) begin
            cnt++;
            if (poke) begin
                iPenDraw = (cnt == 100);
                iRdReq   = (cnt == 100);
                iRdAddr  = 10'd66;
                iClear   = (cnt == 300);
            end
            tick();
            if (poke && cnt == 100) chk({tag, "_rd_busy"}, 32'(oRdValid), 32'd0);
        end
        iPenDraw = 1'b0;
        iRdReq   = 1'b0;
        iClear   = 1'b0;
        chk({tag, "_len"}, 32'(cnt), 32'd1024);
    endtask

    initial begin
        int hs_low;
        int vs_low;
        int bad;
        int vcnt;

        iRstN = 1'b0; iCurX = 11'd700; iCurY = 11'd700;
        iPenDraw = 1'b0; iPenErase = 1'b0; iClear = 1'b0;
        iRdReq = 1'b0; iRdAddr = '0;

        // 1. reset values, then sync timing
        repeat (3) @(posedge clkVga);
        #1;
        chk("rst_hs", 32'(oHs), 32'd1);
        chk("rst_vs", 32'(oVs), 32'd1);
        chk("rst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_valid", 32'(oRdValid), 32'd0);
        chk("rst_fs", 32'(oFrameStart), 32'd0);
        iRstN = 1'b1;
        n = 0; fs_count = 0; hs_low = 0; vs_low = 0;
        while (n < 4230) begin
            tick();
            if (n <= 1056 && oHs === 1'b0) hs_low++;
            if (oVs === 1'b0) vs_low++;
            if (n == 1) begin
                chk("fs_first", 32'(oFrameStart), 32'd1);
                chk("blank_rgb", {20'd0, oRed, oGreen, oBlue}, 32'h222);
            end
            if (n == 1056) chk("hs_end_line", 32'(oHs), 32'd1);
            if (n == 1057) chk("hs_period", 32'(oHs), 32'd0);
        end
        chk("hs_low_len", 32'(hs_low), 32'd128);
        chk("vs_low_len", 32'(vs_low), 32'd4224);
        chk("vs_high_after", 32'(oVs), 32'd1);

        // 2. clear, then every cell reads 0
        chk("busy_idle", 32'(oBusy), 32'd0);
        run_clear("clr1", 1'b0);
        bad = 0; vcnt = 0;
        for (int a = 0; a < 1024; a++) begin
            iRdReq  = 1'b1;
            iRdAddr = 10'(a);
            tick();
            if (oRdValid === 1'b1) vcnt++;
            if (oRdData !== 1'b0) bad++;
        end
        iRdReq = 1'b0;
        chk("readall_valid", 32'(vcnt), 32'd1024);
        chk("readall_zero", 32'(bad), 32'd0);

        // 3. single-cycle draw at (40,40) sets cell {2,2}
        iCurX = 11'd40; iCurY = 11'd40; iPenDraw = 1'b1;
        tick();
        iPenDraw = 1'b0;
        rd("cell_2_2", 66, 1'b1);
        rd("cell_2_1", 65, 1'b0);
        rd("cell_2_3", 67, 1'b0);
        rd("cell_1_2", 34, 1'b0);
        rd("cell_3_2", 98, 1'b0);
        check_px("px_ink_35_35", 35, 35, 12'hF0F);
        check_px("px_white_100_35", 100, 35, 12'hFFF);
        check_px("px_white_600_35", 600, 35, 12'hFFF);

        // 4. both pens held: erase wins; colliding read returns pre-write value
        iPenDraw = 1'b1; iPenErase = 1'b1;
        rd("rw_collide", 66, 1'b1);
        check_px("px_green_40_40", 40, 40, 12'h0F0);
        check_px("px_green_44_40", 44, 40, 12'h0F0);
        check_px("px_white_48_40", 48, 40, 12'hFFF);
        iPenDraw = 1'b0; iPenErase = 1'b0;
        rd("erased_2_2", 66, 1'b0);
        check_px("px_red_40_41", 40, 41, 12'hF00);
        iPenDraw = 1'b1;
        check_px("px_ink_32_42", 32, 42, 12'hF0F);
        check_px("px_blue_40_42", 40, 42, 12'h00F);
        iPenDraw = 1'b0;
        check_px("px_hfp_blank", 820, 42, 12'h222);

        // 5. out-of-grid pens write nothing; edge cell does; reads ignored while busy
        iCurX = 11'd600; iCurY = 11'd100; iPenDraw = 1'b1; tick();
        iCurX = 11'd40;  iCurY = 11'd520; tick();
        iCurX = 11'd512; iCurY = 11'd40;  tick();
        iCurX = 11'd511; iCurY = 11'd511; tick();
        iPenDraw = 1'b0;
        rd("oob_x_wrap", 197, 1'b0);
        rd("oob_y_wrap", 2, 1'b0);
        rd("oob_x512_wrap", 64, 1'b0);
        rd("edge_cell", 1023, 1'b1);
        iCurX = 11'd40; iCurY = 11'd40;
        run_clear("clr2", 1'b1);
        rd("pen_ignored_clr", 66, 1'b0);
        rd("edge_cleared", 1023, 1'b0);
        iPenDraw = 1'b1; tick(); iPenDraw = 1'b0;
        rd("redraw_2_2", 66, 1'b1);
        chk("fs_once", 32'(fs_count), 32'd1);

        // 6. asynchronous reset at clear address 500
        iClear = 1'b1; tick(); iClear = 1'b0;
        repeat (500) tick();
        chk("busy_mid", 32'(oBusy), 32'd1);
        iRstN = 1'b0;
        #1;
        chk("arst_busy", 32'(oBusy), 32'd0);
        chk("arst_hs", 32'(oHs), 32'd1);
        chk("arst_vs", 32'(oVs), 32'd1);
        chk("arst_rgb", {20'd0, oRed, oGreen, oBlue}, 32'd0);
        chk("arst_valid", 32'(oRdValid), 32'd0);
        chk("arst_data", 32'(oRdData), 32'd0);
        chk("arst_fs", 32'(oFrameStart), 32'd0);
        @(posedge clkVga);
        #1;
        iRstN = 1'b1;
        n = 0; fs_count = 0;
        tick();
        chk("resume_hs", 32'(oHs), 32'd0);
        chk("resume_fs", 32'(oFrameStart), 32'd1);
        chk("resume_busy", 32'(oBusy), 32'd0);
        while (n < 128) tick();
        chk("resume_hs_128", 32'(oHs), 32'd0);
        tick();
        chk("resume_hs_129", 32'(oHs), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
